seven_seg_scanner: RTL

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It drives a shared segment bus plus one active-low anode per digit. Each digit is decoded in turn from a frame-latched BCD/dot snapshot. Each digit slot starts with an anti-ghosting blank interval. The block sits between the stopwatch/timer counters and the board display pins.

---
 rtl/seven_seg_pkg.sv | 36 +++
 rtl/seven_seg_scan_decode.sv | 45 ++++
 rtl/seven_seg_scanner.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared types and constants for the seven-segment scan
//            controller. Provides the scan state encoding, the fully blank
//            segment bus value and the active-low 7-bit segment fields
//            (g..a) for BCD digits 0-9.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } state_e;

   // Whole bus off, decimal point included
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // 7-bit segment fields, bit6..0 = g..a, active-low
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_scan_decode.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_decode
// Purpose  : Combinational BCD + decimal point to active-low segment bus.
//            Codes 10-15 and suppressed digits light no segments; the
//            decimal point always follows dot_i.
// Ports    : bcd_i    [3:0] BCD digit value
//            dot_i          active-high decimal point
//            blank_i        force segments g..a off (leading-zero blanking)
//            seg_n_o  [7:0] bit7 = dp, bits6:0 = g..a, active-low
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       dot_i,
   input  logic       blank_i,
   output logic [7:0] seg_n_o
);

   logic [6:0] seg_field;

   always_comb begin
      seg_field = SEG_OFF;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_field = SEG_0;
            4'd1:    seg_field = SEG_1;
            4'd2:    seg_field = SEG_2;
            4'd3:    seg_field = SEG_3;
            4'd4:    seg_field = SEG_4;
            4'd5:    seg_field = SEG_5;
            4'd6:    seg_field = SEG_6;
            4'd7:    seg_field = SEG_7;
            4'd8:    seg_field = SEG_8;
            4'd9:    seg_field = SEG_9;
            default: seg_field = SEG_OFF;
         endcase
      end
      seg_n_o = {~dot_i, seg_field};
   end

endmodule : seven_seg_scan_decode
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//            seven-segment display. Each DIGIT_CYCLES slot starts with
//            BLANK_CYCLES of all anodes off (anti-ghosting), then drives the
//            selected anode. Digits/dots are snapshotted at frame start so a
//            frame never shows a mix of old and new values.
// Config   : `define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading
//            zeros (digit 0 never suppressed). Default build: no suppression.
// Ports    : clk              system clock
//            rst_n            asynchronous active-low reset
//            enable           scan enable; low blanks the display
//            digits [4N-1:0]  BCD per digit, digit 0 rightmost
//            dots   [N-1:0]   active-high decimal points
//            seg_n  [7:0]     dp + g..a, active-low, registered
//            an_n   [N-1:0]   one-hot active-low anode, registered
//            frame_done       one-cycle pulse in the last ON cycle of a frame
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dots,
   output logic [7:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    frame_done
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
      $error("seven_seg_scanner: NUM_DIGITS must be in 2..16");
   end
   if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
      $error("seven_seg_scanner: need 1 <= BLANK_CYCLES < DIGIT_CYCLES");
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   digits_q, digits_d;
   logic [NUM_DIGITS-1:0]     dots_q, dots_d;
   logic [7:0]                seg_n_q, seg_n_d;
   logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
   logic                      frame_done_q, frame_done_d;
   logic                      load;

   logic [3:0]                cur_bcd;
   logic                      cur_dot;
   logic                      cur_supp;
   logic [7:0]                cur_seg_n;

   // Next-state logic. Outputs are registered from the *next* state so that
   // seg_n already carries the new digit's pattern on the first BLANK cycle
   // and frame_done lines up with the final ON cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      digits_d = digits_q;
      dots_d   = dots_q;
      load     = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         BLANK: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               if (cnt_q == BLANK_LAST) state_d = ON;
               cnt_d = cnt_q + 1'b1;
            end
         end
         ON: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end else if (cnt_q == SLOT_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  load  = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      if (load) begin
         digits_d = digits;
         dots_d   = dots;
      end
   end

   // ------------------------------------------------------------------------
   // Leading-zero suppression mask, evaluated once per frame at load time
   // ------------------------------------------------------------------------
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] supp_q, supp_d, supp_new;
   logic                  supp_run;

   always_comb begin
      supp_new = '0;
      supp_run = 1'b1;
      // Walk from the most significant digit down; stop at the first
      // nonzero value or set dot. Digit 0 is never part of the walk.
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         supp_run    = supp_run & (digits[4*i +: 4] == 4'd0) & ~dots[i];
         supp_new[i] = supp_run;
      end
      supp_d = load ? supp_new : supp_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) supp_q <= '0;
      else        supp_q <= supp_d;
   end

   assign cur_supp = supp_d[idx_d];
`else
   assign cur_supp = 1'b0;
`endif

   // Single decoder on the muxed (next) snapshot digit
   assign cur_bcd = digits_d[{idx_d, 2'b00} +: 4];
   assign cur_dot = dots_d[idx_d];

   seven_seg_scan_decode u_decode (
      .bcd_i   (cur_bcd),
      .dot_i   (cur_dot),
      .blank_i (cur_supp),
      .seg_n_o (cur_seg_n)
   );

   always_comb begin
      seg_n_d      = (state_d == IDLE) ? SEG_BLANK : cur_seg_n;
      an_n_d       = (state_d == ON) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      frame_done_d = (state_d == ON) && (cnt_d == SLOT_LAST) && (idx_d == IDX_LAST);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         digits_q     <= '0;
         dots_q       <= '0;
         seg_n_q      <= SEG_BLANK;
         an_n_q       <= '1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         digits_q     <= digits_d;
         dots_q       <= dots_d;
         seg_n_q      <= seg_n_d;
         an_n_q       <= an_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg_n      = seg_n_q;
   assign an_n       = an_n_q;
   assign frame_done = frame_done_q;

endmodule : seven_seg_scanner
`default_nettype wire
